// File: rtl/axi_ar_route_pkg.sv
// Shared types and constants for the AR routing controller.
package axi_ar_route_pkg;

  // Width of the AR burst-length field carried into a DECERR burst.
  localparam int DECERR_LEN_W = 8;

  // Controller states.
  // ROUTE:      forward or reject requests.
  // DRAIN:      wait for the allocator to empty before switching destination.
  // ERR_SAMPLE: the allocator latches the error fields.
  // ERR_WAIT:   wait until the DECERR burst has been returned.
  typedef enum logic [1:0] {
    ROUTE      = 2'd0,
    DRAIN      = 2'd1,
    ERR_SAMPLE = 2'd2,
    ERR_WAIT   = 2'd3
  } ar_route_state_e;

endpackage

// File: rtl/axi_ar_route_ctrl_if.sv
// Signal bundle for one AR routing controller: the target-side AR channel,
// the address map, the initiator-side AR valid/ready, the response-allocator
// sideband, and a debug view of the controller state.
//
// Handshake rule on both AR sides: a transfer happens in a cycle where valid
// and ready are both high. Once valid is raised it stays high, with address,
// id, len and user held stable, until that transfer cycle. Ready may depend
// combinationally on valid.
//
// Modport slave is the controller; modport master is its environment.
interface axi_ar_route_ctrl_if
  import axi_ar_route_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_USER_W  = 6
) ();

  // Target-side AR channel
  logic                                  arvalid_i;
  logic [AXI_ADDR_W-1:0]                 araddr_i;
  logic [AXI_ID_IN-1:0]                  arid_i;
  logic [7:0]                            arlen_i;
  logic [AXI_USER_W-1:0]                 aruser_i;
  logic                                  arready_o;

  // Address map
  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr_i;
  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr_i;
  logic [N_INIT_PORT-1:0]                 enable_region_i;

  // Initiator-side AR valid/ready
  logic [N_INIT_PORT-1:0]                arvalid_o;
  logic [N_INIT_PORT-1:0]                arready_i;

  // Response allocator sideband
  logic                                  incr_req_o;
  logic                                  full_counter_i;
  logic                                  outstanding_trans_i;
  logic                                  error_req_o;
  logic                                  error_gnt_i;
  logic [DECERR_LEN_W-1:0]               error_len_o;
  logic [AXI_USER_W-1:0]                 error_user_o;
  logic [AXI_ID_IN-1:0]                  error_id_o;
  logic                                  sample_ardata_info_o;

  // Debug view of the controller state
  ar_route_state_e                       dbg_state;

  modport slave (
    input  arvalid_i, araddr_i, arid_i, arlen_i, aruser_i,
    input  start_addr_i, end_addr_i, enable_region_i,
    input  arready_i, full_counter_i, outstanding_trans_i, error_gnt_i,
    output arready_o, arvalid_o, incr_req_o, error_req_o,
    output error_len_o, error_user_o, error_id_o, sample_ardata_info_o,
    output dbg_state
  );

  modport master (
    output arvalid_i, araddr_i, arid_i, arlen_i, aruser_i,
    output start_addr_i, end_addr_i, enable_region_i,
    output arready_i, full_counter_i, outstanding_trans_i, error_gnt_i,
    input  arready_o, arvalid_o, incr_req_o, error_req_o,
    input  error_len_o, error_user_o, error_id_o, sample_ardata_info_o,
    input  dbg_state
  );

endinterface

// File: rtl/axi_ar_addr_decoder.sv
// Combinational address decoder: inclusive unsigned range compare against
// every enabled region; the lowest matching index wins.
module axi_ar_addr_decoder #(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ADDR_W  = 32,
  parameter int LOG_N_INIT  = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
  input  logic [AXI_ADDR_W-1:0]                  addr,
  input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr,
  input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr,
  input  logic [N_INIT_PORT-1:0]                 enable_region,
  output logic [LOG_N_INIT-1:0]                  sel,
  output logic                                   hit
);

  // Scan from the top index down so the lowest match is written last.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int k = N_INIT_PORT - 1; k >= 0; k--) begin
      if (enable_region[k] && (addr >= start_addr[k]) && (addr <= end_addr[k])) begin
        hit = 1'b1;
        sel = LOG_N_INIT'(k);
      end
    end
  end

endmodule

// File: rtl/axi_ar_route_ctrl.sv
// Read-address routing controller for one target port.
// Decodes each AR, forwards hits combinationally to one initiator port,
// bumps the response allocator on every forwarded burst, and hands
// unmapped requests to the allocator as DECERR bursts.
// Optional feature macro: AXI_AR_ROUTE_ORDER_LOCK_EN -- when defined, a
// request to a different initiator than the last one waits (DRAIN) until
// the allocator has no bursts in flight, so responses cannot reorder.
module axi_ar_route_ctrl
  import axi_ar_route_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_USER_W  = 6,
  parameter int LOG_N_INIT  = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_ar_route_ctrl_if.slave   bus
);

  ar_route_state_e          state_q, state_d;
  logic [LOG_N_INIT-1:0]    sel;
  logic                     hit;
  logic [N_INIT_PORT-1:0]   arvalid_d;
  logic                     arready_d;
  logic                     incr_d;
  logic                     err_req_d;
  logic                     sample_d;
  logic                     capture;
  logic                     order_stall;

  logic [DECERR_LEN_W-1:0]  err_len_q;
  logic [AXI_ID_IN-1:0]     err_id_q;
  logic [AXI_USER_W-1:0]    err_user_q;

  axi_ar_addr_decoder #(
    .N_INIT_PORT (N_INIT_PORT),
    .AXI_ADDR_W  (AXI_ADDR_W),
    .LOG_N_INIT  (LOG_N_INIT)
  ) u_decoder (
    .addr          (bus.araddr_i),
    .start_addr    (bus.start_addr_i),
    .end_addr      (bus.end_addr_i),
    .enable_region (bus.enable_region_i),
    .sel           (sel),
    .hit           (hit)
  );

`ifdef AXI_AR_ROUTE_ORDER_LOCK_EN
  logic [LOG_N_INIT-1:0] last_dest_q;
  logic                  dest_valid_q;

  // Remember where the last forwarded burst went.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dest_q  <= '0;
      dest_valid_q <= 1'b0;
    end else if (incr_d) begin
      last_dest_q  <= sel;
      dest_valid_q <= 1'b1;
    end
  end

  assign order_stall = bus.outstanding_trans_i && dest_valid_q && (sel != last_dest_q);
`else
  assign order_stall = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ROUTE;
    else        state_q <= state_d;
  end

  // Next state and outputs; a miss is accepted at once and never forwarded.
  always_comb begin
    state_d   = state_q;
    arvalid_d = '0;
    arready_d = 1'b0;
    incr_d    = 1'b0;
    err_req_d = 1'b0;
    sample_d  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ROUTE: begin
        if (bus.arvalid_i) begin
          if (!hit) begin
            arready_d = 1'b1;
            capture   = 1'b1;
            state_d   = ERR_SAMPLE;
          end else if (!bus.full_counter_i) begin
            if (order_stall) begin
              state_d = DRAIN;
            end else begin
              arvalid_d[sel] = 1'b1;
              arready_d      = bus.arready_i[sel];
              incr_d         = bus.arready_i[sel];
            end
          end
        end
      end
      DRAIN: begin
        if (!bus.outstanding_trans_i) state_d = ROUTE;
      end
      ERR_SAMPLE: begin
        err_req_d = 1'b1;
        sample_d  = 1'b1;
        state_d   = ERR_WAIT;
      end
      ERR_WAIT: begin
        err_req_d = 1'b1;
        if (bus.error_gnt_i) state_d = ROUTE;
      end
      default: state_d = ROUTE;
    endcase
  end

  // Capture the failing request's attributes; held until the next miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_len_q  <= '0;
      err_id_q   <= '0;
      err_user_q <= '0;
    end else if (capture) begin
      err_len_q  <= bus.arlen_i;
      err_id_q   <= bus.arid_i;
      err_user_q <= bus.aruser_i;
    end
  end

  assign bus.arvalid_o            = arvalid_d;
  assign bus.arready_o            = arready_d;
  assign bus.incr_req_o           = incr_d;
  assign bus.error_req_o          = err_req_d;
  assign bus.sample_ardata_info_o = sample_d;
  assign bus.error_len_o          = err_len_q;
  assign bus.error_id_o           = err_id_q;
  assign bus.error_user_o         = err_user_q;
  assign bus.dbg_state            = state_q;

endmodule

// File: doc/axi_ar_route_ctrl.md
# axi_ar_route_ctrl

Read-address routing controller for one target port of the AXI node. It decodes each incoming AR address against the per-initiator address map and forwards the request to the matching initiator port. It also sequences the read-response allocator of the same target port: it bumps that allocator's outstanding counter and hands it decode-error bursts to synthesize. When enabled, it holds back requests that would reorder responses across initiators.

## Interface
- N_INIT_PORT, 4: number of initiator (slave-side) ports.
- AXI_ADDR_W, 32: address width.
- AXI_ID_IN, 16: target-side ID width.
- AXI_USER_W, 6: AR user width.
- LOG_N_INIT, $clog2(N_INIT_PORT) (min 1): destination index width.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- arvalid_i  in  1  AR request from target port.
- araddr_i  in  AXI_ADDR_W  AR address.
- arid_i  in  AXI_ID_IN  AR ID.
- arlen_i  in  8  AR burst length.
- aruser_i  in  AXI_USER_W  AR user.
- arready_o  out  1  AR accept to target port.
- start_addr_i  in  N_INIT_PORT×AXI_ADDR_W  region base, inclusive.
- end_addr_i  in  N_INIT_PORT×AXI_ADDR_W  region end, inclusive.
- enable_region_i  in  N_INIT_PORT  region enable.
- arvalid_o  out  N_INIT_PORT  one-hot AR request to initiators.
- arready_i  in  N_INIT_PORT  initiator AR ready.
- incr_req_o  out  1  pulse to the response allocator: one burst issued.
- full_counter_i  in  1  allocator outstanding counter saturated.
- outstanding_trans_i  in  1  allocator has bursts in flight.
- error_req_o  out  1  request a DECERR burst.
- error_gnt_i  in  1  error burst completed.
- error_len_o  out  8  registered arlen of the failing request.
- error_user_o  out  AXI_USER_W  registered aruser.
- error_id_o  out  AXI_ID_IN  registered arid.
- sample_ardata_info_o  out  1  allocator latches the error_* fields.

## Operation
- **Decode:** region k matches when enable_region_i[k] is set and start ≤ araddr ≤ end, unsigned. The lowest matching index wins. No match means a decode error.
- **States:** ROUTE, DRAIN, ERR_SAMPLE, ERR_WAIT. Reset state is ROUTE.
- **ROUTE, hit, no stall:**
  - arvalid_o[sel] = arvalid_i; arready_o = arready_i[sel].
  - On handshake: incr_req_o = 1, last_dest ← sel, dest_valid ← 1.
- **Stall (full):** when full_counter_i = 1, arvalid_o = 0 and arready_o = 0; remain in ROUTE.
- **Stall (ordering):** when the ordering feature is on, outstanding_trans_i = 1, dest_valid = 1 and sel ≠ last_dest, move to DRAIN. Outputs are gated off in that cycle.
- **DRAIN:** arvalid_o = 0, arready_o = 0. Return to ROUTE when outstanding_trans_i = 0.
- **ROUTE, miss:**
  - arready_o = 1 in the same cycle.
  - arid/arlen/aruser are registered into error_id_o/error_len_o/error_user_o.
  - No arvalid_o, no incr_req_o. Move to ERR_SAMPLE.
- **ERR_SAMPLE:** error_req_o = 1, sample_ardata_info_o = 1 (this cycle only), arready_o = 0. Move to ERR_WAIT.
- **ERR_WAIT:** error_req_o = 1, arready_o = 0. On error_gnt_i, move to ROUTE; error_req_o deasserts in the following cycle. error_gnt_i in ERR_SAMPLE is ignored.
- **Hold rule:** error_* outputs stay constant from ERR_SAMPLE until the next miss.
- **Reset values:** all outputs 0; error_* fields 0; last_dest 0; dest_valid 0.
- **Reset mid-operation:** an abandoned error or drain is dropped; the FSM returns to ROUTE.

## Timing
- Hit path is combinational: zero added latency from arvalid_i to arvalid_o, and from arready_i to arready_o.
- incr_req_o is combinational, asserted in the handshake cycle.
- Miss: accept at cycle 0; error_req_o and sample_ardata_info_o at cycle 1.
- Simultaneous full_counter_i and a decrement: stall anyway; the counter frees next cycle.
- arvalid_i with arready_o = 0 must hold the address stable (AXI rule). Decode is re-evaluated each cycle.

## Configuration
- AXI_AR_ROUTE_ORDER_LOCK_EN defined: destination-change ordering stall active; DRAIN reachable.
- Undefined: no ordering stall. DRAIN is unreachable; last_dest/dest_valid may be removed. This suits systems with unique IDs per initiator.

## Structure
- Shared package axi_ar_route_pkg holds:
  - the state enum typedef (ROUTE, DRAIN, ERR_SAMPLE, ERR_WAIT);
  - the DECERR length width constant (8).
- One combinational sub-module, axi_ar_addr_decoder: range compare plus priority encoder. Outputs sel (LOG_N_INIT bits) and hit.

## Test plan
- Region 1 = 0x1000–0x1FFF, araddr 0x1800, arready_i[1] = 1 -> arvalid_o = 0b0010, handshake cycle 0, incr_req_o one cycle.
- araddr 0x9000 unmapped, arlen 3, arid 0x5 -> arready_o cycle 0; cycle 1 error_req_o = 1, sample_ardata_info_o = 1, error_len_o = 3, error_id_o = 0x5; error_gnt_i at cycle 6 -> error_req_o low at cycle 7.
- full_counter_i = 1 with a valid hit -> arvalid_o = 0 and arready_o = 0 until full drops, then the handshake occurs.
- Ordering on: burst to port 0 outstanding, new AR to port 2 -> DRAIN with no arvalid_o; outstanding_trans_i falls -> arvalid_o = 0b0100 within 2 cycles.
- Overlapping regions 0 and 1 both match -> port 0 selected.
- Assert rst_n during ERR_WAIT -> error_req_o = 0 immediately; ROUTE after reset release.
